// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester bridge.
// Struct widths follow the default AWIDTH/DWIDTH.
package apb_pkg;

  localparam int APB_AWIDTH = 8;
  localparam int APB_DWIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_AWIDTH-1:0] addr;
    logic [APB_DWIDTH-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DWIDTH-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states. Flags expiry on the wait cycle that
// brings the count up to the limit.
module apb_wait_timer #(
  parameter int CWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [CWIDTH-1:0] limit,
  output logic              expired
);

  logic [CWIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CWIDTH'(1);
    end
  end

  // The limit is at least 1, so the subtraction never underflows.
  assign expired = enable && (count == (limit - CWIDTH'(1)));

endmodule

// File: rtl/apb_master_bridge.sv
// Converts valid/ready commands into APB SETUP/ACCESS transfers and
// returns one response per command, aborting stalled transfers.
//
// state  | meaning
// IDLE   | no transfer; ready to accept a command
// SETUP  | p_sel=1, p_en=0 for one cycle
// ACCESS | p_sel=1, p_en=1 until p_ready or wait-state timeout
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int AWIDTH  = APB_AWIDTH,
  parameter int DWIDTH  = APB_DWIDTH,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              p_sel,
  output logic              p_en,
  output logic              p_write,
  output logic [AWIDTH-1:0] addr,
  output logic [DWIDTH-1:0] wdata,
  input  logic [DWIDTH-1:0] rdata,
  input  logic              p_ready
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  apb_state_e state, state_nxt;
  logic       load;
  logic       done;
  logic       abort;
  logic       expired;

  apb_wait_timer #(.CWIDTH(8)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == SETUP),
    .enable ((state == ACCESS) && !p_ready),
    .limit  (LIMIT),
    .expired(expired)
  );

  // Select/enable decode straight from state so reset drops them at once.
  assign p_sel     = (state != IDLE);
  assign p_en      = (state == ACCESS);
  assign cmd_ready = (state == IDLE) | ((state == ACCESS) & p_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          load      = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        // Completion takes priority over an expiring timer.
        if (p_ready) begin
          done = 1'b1;
          if (cmd_valid) begin
            load      = 1'b1;
            state_nxt = SETUP;
          end else begin
            state_nxt = IDLE;
          end
        end else if (expired) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_write   <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= done | abort;
      if (load) begin
        p_write <= cmd_write;
        addr    <= cmd_addr;
        wdata   <= cmd_wdata;
      end
      if (done) begin
        rsp_rdata <= p_write ? '0 : rdata;
        rsp_err   <= 1'b0;
      end else if (abort) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed plus randomized bench for apb_master_bridge with a wait-state
// programmable slave and a memory/latency reference model.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int TO = 16;

  typedef struct {
    apb_rsp_t rsp;
    int       cyc;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        p_sel, p_en, p_write, p_ready;
  logic [7:0]  addr;
  logic [31:0] wdata, rdata;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int sel_cnt = 0, en_cnt = 0, sel_rises = 0;
  logic sel_prev = 1'b0;

  logic [31:0] mem     [256] = '{default: '0};
  logic [31:0] ref_mem [256] = '{default: '0};
  logic [7:0]  cur_wait = 8'd0;
  logic [7:0]  acc_cnt  = 8'd0;
  int          wait_q[$];
  apb_cmd_t    cmd_q[$];
  apb_cmd_t    hold_cmd;
  rec_t        exp_q[$];
  rec_t        obs_q[$];
  int          acc_log[$];

  apb_master_bridge #(.AWIDTH(8), .DWIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .p_sel(p_sel), .p_en(p_en), .p_write(p_write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .p_ready(p_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave: per-transfer wait count taken from wait_q at SETUP.
  assign p_ready = (acc_cnt >= cur_wait);
  assign rdata   = mem[addr];
  always @(posedge clk) begin
    if (p_sel && !p_en) cur_wait <= (wait_q.size() > 0) ? 8'(wait_q.pop_front()) : 8'd0;
    if (p_sel && p_en && !p_ready) acc_cnt <= acc_cnt + 8'd1;
    else acc_cnt <= 8'd0;
    if (p_sel && p_en && p_ready && p_write) mem[addr] <= wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid) obs_q.push_back('{rsp: '{rdata: rsp_rdata, err: rsp_err}, cyc: cyc});
    if (p_sel) sel_cnt++;
    if (p_en) en_cnt++;
    if (p_sel && !sel_prev) sel_rises++;
    sel_prev = p_sel;
    if (p_sel && !p_en) begin
      if (cmd_q.size() == 0) begin
        check("setup_unexpected", 32'(cmd_q.size()), 32'd1);
      end else begin
        hold_cmd = cmd_q.pop_front();
        check("setup_addr", 32'(addr), 32'(hold_cmd.addr));
        check("setup_write", 32'(p_write), 32'(hold_cmd.write));
        if (hold_cmd.write) check("setup_wdata", wdata, hold_cmd.wdata);
      end
    end
    if (p_en) begin
      check("hold_addr", 32'(addr), 32'(hold_cmd.addr));
      check("hold_write", 32'(p_write), 32'(hold_cmd.write));
      if (hold_cmd.write) check("hold_wdata", wdata, hold_cmd.wdata);
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  // with cmd_valid still high.
  task automatic send(input logic wr, input logic [7:0] a, input logic [31:0] d, input int w);
    int   budget;
    rec_t e;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    budget = 0;
    while (!cmd_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    acc_log.push_back(cyc);
    wait_q.push_back(w);
    cmd_q.push_back('{write: wr, addr: a, wdata: d});
    if (w >= TO) begin
      e = '{rsp: '{rdata: 32'd0, err: 1'b1}, cyc: cyc + TO + 2};
    end else begin
      e = '{rsp: '{rdata: wr ? 32'd0 : ref_mem[a], err: 1'b0}, cyc: cyc + 3 + w};
      if (wr) ref_mem[a] = d;
    end
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int   budget;
    rec_t o, e;
    budget = 0;
    while (obs_q.size() < exp_q.size() && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    repeat (2) @(negedge clk);
    #1;
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_rdata"}, o.rsp.rdata, e.rsp.rdata);
      check({tag, "_err"}, 32'(o.rsp.err), 32'(e.rsp.err));
      check({tag, "_cycle"}, 32'(o.cyc), 32'(e.cyc));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    int s0, e0, r0;
    int waits[10] = '{0, 0, 0, 1, 1, 2, 3, 15, 16, 40};
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = 8'd0;
    cmd_wdata = 32'd0;
    #3;
    check("rst_p_sel", 32'(p_sel), 32'd0);
    check("rst_p_en", 32'(p_en), 32'd0);
    check("rst_p_write", 32'(p_write), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Zero-wait write then read-back.
    s0 = sel_cnt; e0 = en_cnt;
    send(1'b1, 8'h14, 32'hDEADBEEF, 0);
    cmd_valid = 1'b0;
    drain("wr14");
    check("wr14_sel_cycles", 32'(sel_cnt - s0), 32'd2);
    check("wr14_en_cycles", 32'(en_cnt - e0), 32'd1);
    s0 = sel_cnt;
    send(1'b0, 8'h14, 32'h0, 0);
    cmd_valid = 1'b0;
    drain("rd14");
    check("rd14_sel_cycles", 32'(sel_cnt - s0), 32'd2);
    check("rd14_rdata_hold", rsp_rdata, 32'hDEADBEEF);

    // Read with three wait states.
    send(1'b1, 8'h20, 32'hA5A50F0F, 1);
    cmd_valid = 1'b0;
    drain("wr20");
    e0 = en_cnt;
    send(1'b0, 8'h20, 32'h0, 3);
    cmd_valid = 1'b0;
    drain("rd20_wait3");
    check("rd20_en_cycles", 32'(en_cnt - e0), 32'd4);

    // Four back-to-back writes.
    r0 = sel_rises; s0 = sel_cnt;
    acc_log.delete();
    for (int i = 0; i < 4; i++) send(1'b1, 8'(i), 32'h1000 + 32'(i), 0);
    cmd_valid = 1'b0;
    drain("b2b");
    check("b2b_sel_rises", 32'(sel_rises - r0), 32'd1);
    check("b2b_sel_cycles", 32'(sel_cnt - s0), 32'd8);
    for (int i = 0; i < 3; i++) check("b2b_accept_spacing", 32'(acc_log[i+1] - acc_log[i]), 32'd2);
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 8'(i), 32'h0, 0);
      cmd_valid = 1'b0;
    end
    drain("b2b_readback");

    // Timeout, then a normal transfer.
    e0 = en_cnt;
    send(1'b0, 8'h20, 32'h0, 255);
    cmd_valid = 1'b0;
    drain("timeout");
    check("timeout_en_cycles", 32'(en_cnt - e0), 32'(TO));
    check("timeout_p_sel", 32'(p_sel), 32'd0);
    send(1'b1, 8'h05, 32'h0BADF00D, 0);
    send(1'b0, 8'h05, 32'h0, 2);
    cmd_valid = 1'b0;
    drain("after_timeout");

    // Ready on the limit cycle completes normally.
    send(1'b0, 8'h14, 32'h0, TO - 1);
    cmd_valid = 1'b0;
    drain("limit_complete");

    // Reset during ACCESS of a read.
    send(1'b0, 8'h14, 32'h0, 6);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_p_en", 32'(p_en), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_p_sel", 32'(p_sel), 32'd0);
    check("async_rst_p_en", 32'(p_en), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (8) @(negedge clk);
    check("post_rst_no_rsp", 32'(obs_q.size()), 32'd0);
    send(1'b0, 8'h14, 32'h0, 1);
    cmd_valid = 1'b0;
    drain("post_rst_read");

    // Randomized traffic with random gaps and wait states.
    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
           waits[$urandom_range(0, 9)]);
      if (gap > 0) begin
        cmd_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
